// File: rtl/gpio_input_conditioner.sv
// Purpose: synchronise, debounce and edge-detect board KEY/SW inputs; sticky change mask + irq.
// Latency: 2 sync cycles + STABLE_TICKS debounce ticks (+1 register stage) from raw change to db_out.
// Backpressure: none; free-running conditioner, every output is a registered level or 1-cycle pulse.
//
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   raw_in           asynchronous board inputs, bit order {KEY, SW}
//   db_out           debounced, synchronised level (drives the GPIO input bus)
//   rise / fall      one-cycle pulses in the first cycle db_out shows a 0->1 / 1->0 change
//   chg_mask         sticky per-bit "changed since last clear"; chg_irq = registered OR of it
//   clr, clr_mask    one-cycle clear request for the selected chg_mask bits
module gpio_input_conditioner #(
  parameter int               WIDTH        = 22,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 8,
  parameter logic [WIDTH-1:0] INIT_VAL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] chg_mask,
  output logic             chg_irq,
  input  logic             clr,
  input  logic [WIDTH-1:0] clr_mask
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] db_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] mask_nxt;

  assign tick = (pre_cnt == PRE_LAST);

  // Two-flop synchroniser and free-running sample prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a  <= INIT_VAL;
      sync_b  <= INIT_VAL;
      pre_cnt <= '0;
    end else begin
      sync_a  <= raw_in;
      sync_b  <= sync_a;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  always_comb begin
    db_nxt   = db_out;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync_b[i] == db_out[i]) begin
        // Any agreement, even for one cycle, restarts the stability window.
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i]   = sync_b[i];
          rise_nxt[i] = sync_b[i];
          fall_nxt[i] = ~sync_b[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
    // Set wins over clear both for the edge being registered now and for the
    // pulse currently visible on rise/fall, so a clear issued while software
    // sees a pulse can never lose that event.
    mask_nxt = (chg_mask & ~(clr_mask & {WIDTH{clr}}))
             | rise | fall | rise_nxt | fall_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_out   <= INIT_VAL;
      rise     <= '0;
      fall     <= '0;
      chg_mask <= '0;
      chg_irq  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      db_out   <= db_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      chg_mask <= mask_nxt;
      chg_irq  <= |mask_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios followed by random input activity,
// with a reference model pushing expected outputs per clock edge into a queue that an
// independent monitor pops and compares one cycle at a time.
module tb_gpio_input_conditioner;

  localparam int         W    = 4;
  localparam int         TDIV = 4;
  localparam int         ST   = 3;
  localparam logic [3:0] INIT = 4'b1000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in = 4'b0101;
  logic [W-1:0] db_out, rise, fall, chg_mask;
  logic         chg_irq;
  logic         clr = 1'b0;
  logic [W-1:0] clr_mask = '0;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b1;

  gpio_input_conditioner #(
    .WIDTH(W), .TICK_DIV(TDIV), .STABLE_TICKS(ST), .INIT_VAL(INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .db_out(db_out),
    .rise(rise), .fall(fall), .chg_mask(chg_mask), .chg_irq(chg_irq),
    .clr(clr), .clr_mask(clr_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sync value is the raw input delayed by two edges; a tick happens on every
  // TDIV-th edge after reset release; a bit flips once ST ticks have passed
  // while the synchronised input disagreed with the debounced value throughout.
  typedef struct packed {
    logic [3:0] db;
    logic [3:0] rs;
    logic [3:0] fl;
    logic [3:0] mask;
    logic       irq;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_hist[$];
  logic [3:0] m_db = INIT, m_rise = '0, m_fall = '0, m_mask = '0;
  logic       m_irq = 1'b0;
  int         m_edges = 0;
  int         m_run[W];

  always @(posedge clk) begin
    logic [3:0] sync_v, nr, nf;
    if (!reset_n) begin
      m_hist = '{INIT, INIT};
      m_db = INIT; m_rise = '0; m_fall = '0; m_mask = '0; m_irq = 1'b0;
      m_edges = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      sync_v = m_hist.pop_front();
      m_hist.push_back(raw_in);
      nr = '0; nf = '0;
      for (int i = 0; i < W; i++) begin
        if (sync_v[i] == m_db[i]) m_run[i] = 0;
        else if ((m_edges % TDIV) == TDIV - 1) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            nr[i] = sync_v[i];
            nf[i] = ~sync_v[i];
            m_run[i] = 0;
          end
        end
      end
      m_db   = m_db ^ (nr | nf);
      m_mask = (m_mask & ~(clr ? clr_mask : 4'b0000)) | m_rise | m_fall | nr | nf;
      m_irq  = |m_mask;
      m_rise = nr;
      m_fall = nf;
      m_edges++;
    end
    exp_q.push_back('{db: m_db, rs: m_rise, fl: m_fall, mask: m_mask, irq: m_irq});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        chk("sb_queue_nonempty", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_db_out",   {4'b0, db_out},   {4'b0, e.db});
        chk("sb_rise",     {4'b0, rise},     {4'b0, e.rs});
        chk("sb_fall",     {4'b0, fall},     {4'b0, e.fl});
        chk("sb_chg_mask", {4'b0, chg_mask}, {4'b0, e.mask});
        chk("sb_chg_irq",  {7'b0, chg_irq},  {7'b0, e.irq});
      end
    end
  end

  // Counts negedges until db_out[b] == v; 99 on timeout.
  task automatic wait_db(input int b, input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (db_out[b] !== v && n < 40);
    if (db_out[b] !== v) n = 99;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, rcnt, fcnt, first;
    bit seen;
    int idx;

    // Reset with raw inputs disagreeing with INIT
    repeat (3) @(negedge clk);
    chk("reset_db_out",   {4'b0, db_out},   8'h08);
    chk("reset_rise",     {4'b0, rise},     8'h00);
    chk("reset_fall",     {4'b0, fall},     8'h00);
    chk("reset_chg_mask", {4'b0, chg_mask}, 8'h00);
    chk("reset_chg_irq",  {7'b0, chg_irq},  8'h00);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_after_release", {4'b0, db_out}, 8'h08);
      if (k == 7) raw_in = 4'b1000;
    end
    repeat (20) @(negedge clk);

    // Clean press on bit 0
    raw_in[0] = 1'b1;
    wait_db(0, 1'b1, n);
    chk("press_latency_ok", 8'((n >= 11 && n <= 15) ? 1 : 0), 8'd1);
    chk("press_rise",  {4'b0, rise},     8'h01);
    chk("press_mask",  {4'b0, chg_mask}, 8'h01);
    chk("press_irq",   {7'b0, chg_irq},  8'h01);
    @(negedge clk);
    chk("press_rise_one_cycle", {4'b0, rise}, 8'h00);
    repeat (10) @(negedge clk);

    // Bounce on bit 1: toggles every 5 cycles, then settles high
    rcnt = 0; fcnt = 0;
    for (int t = 0; t < 12; t++) begin
      raw_in[1] = ~raw_in[1];
      repeat (5) begin
        @(negedge clk);
        if (rise[1]) rcnt++;
        if (fall[1]) fcnt++;
      end
    end
    chk("bounce_no_pulses", 8'(rcnt + fcnt), 8'd0);
    raw_in[1] = 1'b1;
    rcnt = 0; first = 99;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (rise[1]) begin
        rcnt++;
        if (first == 99) first = k;
      end
    end
    chk("bounce_one_rise", 8'(rcnt), 8'd1);
    chk("bounce_rise_within_15", 8'((first <= 15) ? 1 : 0), 8'd1);

    // Active-low key release on bit 3
    raw_in[3] = 1'b0;
    seen = 1'b0; rcnt = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rise[3]) rcnt++;
      if (fall[3]) begin
        seen = 1'b1;
        chk("release_fall", {4'b0, fall}, 8'h08);
        chk("release_db3",  {7'b0, db_out[3]}, 8'h00);
      end
    end
    chk("release_seen", {7'b0, seen}, 8'h01);
    repeat (5) @(negedge clk);
    chk("release_no_rise3", 8'(rcnt), 8'd0);

    // Clear everything
    clr = 1'b1; clr_mask = 4'b1111;
    @(negedge clk);
    clr = 1'b0; clr_mask = '0;
    chk("clear_all_mask", {4'b0, chg_mask}, 8'h00);
    chk("clear_all_irq",  {7'b0, chg_irq},  8'h00);

    // Clear race: clear issued while rise[1] is visible
    raw_in[0] = 1'b0;
    wait_db(0, 1'b0, n);
    raw_in[1] = 1'b0;
    wait_db(1, 1'b0, n);
    chk("race_pre_mask", {4'b0, chg_mask}, 8'h03);
    raw_in[1] = 1'b1;
    wait_db(1, 1'b1, n);
    chk("race_rise1", {4'b0, rise}, 8'h02);
    clr = 1'b1; clr_mask = 4'b0011;
    @(negedge clk);
    clr = 1'b0; clr_mask = '0;
    chk("race_mask", {4'b0, chg_mask}, 8'h02);
    chk("race_irq",  {7'b0, chg_irq},  8'h01);
    clr = 1'b1; clr_mask = 4'b0010;
    @(negedge clk);
    clr = 1'b0; clr_mask = '0;
    chk("race_clear2_mask", {4'b0, chg_mask}, 8'h00);
    chk("race_clear2_irq",  {7'b0, chg_irq},  8'h00);

    // Reset mid-debounce on bit 2
    raw_in[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("middb_no_flip_yet", {7'b0, db_out[2]}, 8'h00);
    reset_n = 1'b0;
    @(negedge clk);
    chk("middb_reset_db", {4'b0, db_out}, 8'h08);
    reset_n = 1'b1;
    wait_db(2, 1'b1, n);
    chk("middb_full_debounce", 8'((n >= 11 && n <= 15) ? 1 : 0), 8'd1);

    // Random activity, occasional clears and resets
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        idx = int'($urandom_range(W - 1));
        raw_in[idx] = ~raw_in[idx];
      end
      clr      = ($urandom_range(9) == 0);
      clr_mask = 4'($urandom);
      reset_n  = ($urandom_range(499) != 0);
    end
    reset_n = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
